// File: rtl/matmul_row_serializer.sv
// matmul_row_serializer: buffers completed rows of C in a small row FIFO and
// streams them out one element per beat on a valid/ready interface.
module matmul_row_serializer #(
    parameter int BATCH_SIZE          = 8,
    parameter int LOG_BATCH_SIZE      = 3,
    parameter int OUTPUT_FEATURES     = 8,
    parameter int LOG_OUTPUT_FEATURES = 3,
    parameter int OUTPUT_WIDTH        = 16,
    parameter int FIFO_DEPTH          = 4,
    parameter int LOG_FIFO_DEPTH      = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] row_data,
    input  logic [LOG_BATCH_SIZE-1:0]               row_addr,
    input  logic                                    row_wr_en,
    output logic [OUTPUT_WIDTH-1:0]                 m_data,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic                                    m_last,
    output logic [LOG_BATCH_SIZE-1:0]               m_row,
    output logic [LOG_OUTPUT_FEATURES-1:0]          m_col,
    output logic [LOG_FIFO_DEPTH:0]                 fifo_count,
    output logic                                    overflow,
    output logic                                    done
);

    localparam int ROW_W = OUTPUT_FEATURES * OUTPUT_WIDTH;
    localparam logic [LOG_FIFO_DEPTH:0]        FULL_COUNT  = (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);
    localparam logic [LOG_OUTPUT_FEATURES-1:0] LAST_COL    = LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES-1);
    localparam logic [LOG_BATCH_SIZE:0]        BATCH_COUNT = (LOG_BATCH_SIZE+1)'(BATCH_SIZE);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state, next_state;

    logic [ROW_W-1:0]               fifo_data [FIFO_DEPTH];
    logic [LOG_BATCH_SIZE-1:0]      fifo_addr [FIFO_DEPTH];
    logic [LOG_FIFO_DEPTH-1:0]      wr_ptr, rd_ptr;
    logic [LOG_FIFO_DEPTH:0]        count;

    logic [ROW_W-1:0]               cur_row;
    logic [LOG_BATCH_SIZE-1:0]      cur_addr;
    logic [LOG_OUTPUT_FEATURES-1:0] col;
    logic [LOG_BATCH_SIZE:0]        rows_done;
    logic                           done_r;
    logic                           overflow_r;

    logic [OUTPUT_WIDTH-1:0]        elems [OUTPUT_FEATURES];

    logic clear, beat, last_beat, fifo_empty, fifo_full, pop, push;

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // still lands when the serializer is taking the head row.
    assign clear      = reset | start;
    assign beat       = (state == STREAM) && m_ready;
    assign last_beat  = beat && (col == LAST_COL);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign pop        = !fifo_empty && ((state == IDLE) || last_beat);
    assign push       = row_wr_en && (!fifo_full || pop);

    // State register; reset and start both return the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= next_state;
    end

    // Next state: load a row whenever one waits, drop to IDLE only when the
    // final beat of a row finds the FIFO empty.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty) next_state = STREAM;
            STREAM:  if (last_beat && fifo_empty) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from registered state only, so m_ready never reaches m_valid.
    always_comb begin
        for (int c = 0; c < OUTPUT_FEATURES; c++) begin
            elems[c] = cur_row[c*OUTPUT_WIDTH +: OUTPUT_WIDTH];
        end
        m_valid = (state == STREAM);
        m_data  = '0;
        m_row   = '0;
        m_col   = '0;
        m_last  = 1'b0;
        if (m_valid) begin
            m_data = elems[col];
            m_row  = cur_addr;
            m_col  = col;
            m_last = (col == LAST_COL);
        end
    end

    // Row storage; contents beyond the live count are never observed.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            fifo_data[wr_ptr] <= row_data;
            fifo_addr[wr_ptr] <= row_addr;
        end
    end

    // Pointers, occupancy, serializer register and sticky status flags.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cur_row    <= '0;
            cur_addr   <= '0;
            col        <= '0;
            rows_done  <= '0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (row_wr_en && !push) overflow_r <= 1'b1;
            if (pop) begin
                cur_row  <= fifo_data[rd_ptr];
                cur_addr <= fifo_addr[rd_ptr];
                col      <= '0;
            end else if (beat && !last_beat) begin
                col <= col + 1'b1;
            end
            if (last_beat && !done_r) begin
                rows_done <= rows_done + 1'b1;
                if (rows_done + 1'b1 == BATCH_COUNT) done_r <= 1'b1;
            end
        end
    end

    assign fifo_count = count;
    assign overflow   = overflow_r;
    assign done       = done_r;

endmodule
